// File: rtl/aim_cursor.sv
// Aim cursor: 1..NPOS position stepped manually or by a ping-pong sweep, frozen by lock.
// Define AIM_CURSOR_SWEEP_EN to build the SWEEP state and its direction register.
module aim_cursor #(
  parameter int NPOS   = 9,
  parameter int PW     = 4,
  parameter int CENTER = 5,
  parameter int WRAP   = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          left,
  input  logic          right,
  input  logic          sweep,
  input  logic          lock,
  output logic [PW-1:0] pos,
  output logic          locked,
  output logic          moved
);

  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] TWO      = PW'(2);
  localparam logic [PW-1:0] NPOS_P   = PW'(NPOS);
  localparam logic [PW-1:0] CENTER_P = PW'(CENTER);

`ifdef AIM_CURSOR_SWEEP_EN
  typedef enum logic [1:0] {MANUAL = 2'd0, SWEEP = 2'd1, LOCKED = 2'd2} state_t;
  logic dir_up;
`else
  typedef enum logic {MANUAL = 1'b0, LOCKED = 1'b1} state_t;
  logic unused_sweep;
  assign unused_sweep = sweep;
`endif

  state_t        state;
  logic          illegal;
  logic [PW-1:0] man_next;

  assign illegal = (pos == '0) || (pos > NPOS_P);

  always_comb begin
    man_next = pos;
    if (left && !right)
      man_next = (pos == ONE) ? ((WRAP != 0) ? NPOS_P : ONE) : pos - ONE;
    else if (right && !left)
      man_next = (pos == NPOS_P) ? ((WRAP != 0) ? ONE : NPOS_P) : pos + ONE;
  end

`ifdef AIM_CURSOR_SWEEP_EN
  // Sweep bounces off the ends in a single tick, so it never dwells at 1 or NPOS.
  logic [PW-1:0] swp_next;
  logic          swp_dir;
  always_comb begin
    swp_dir  = dir_up;
    swp_next = pos;
    if (dir_up) begin
      if (pos == NPOS_P) begin swp_next = NPOS_P - ONE; swp_dir = 1'b0; end
      else swp_next = pos + ONE;
    end else begin
      if (pos == ONE) begin swp_next = TWO; swp_dir = 1'b1; end
      else swp_next = pos - ONE;
    end
  end
`else
  logic [PW-1:0] unused_two;
  assign unused_two = TWO;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pos    <= CENTER_P;
      state  <= MANUAL;
      locked <= 1'b0;
      moved  <= 1'b0;
`ifdef AIM_CURSOR_SWEEP_EN
      dir_up <= 1'b1;
`endif
    end else begin
      moved <= 1'b0;
      if (state != LOCKED) begin
        if (illegal) begin
          pos   <= CENTER_P;
          moved <= 1'b1;
        end
        if (lock) begin
          state  <= LOCKED;
          locked <= 1'b1;
        end
`ifdef AIM_CURSOR_SWEEP_EN
        else if (state != SWEEP && sweep)
          state <= SWEEP;
        else if (state == SWEEP && !sweep)
          state <= MANUAL;
        else if (tick && !illegal) begin
          if (state == SWEEP) begin
            pos    <= swp_next;
            dir_up <= swp_dir;
            moved  <= (swp_next != pos);
          end else begin
            pos   <= man_next;
            moved <= (man_next != pos);
          end
        end
`else
        else if (tick && !illegal) begin
          pos   <= man_next;
          moved <= (man_next != pos);
        end
`endif
      end
    end
  end

endmodule
